// File: rtl/genome_pkg.sv
// Shared types and constants for the genome k-mer counter.
package genome_pkg;

    localparam int LP_DATA_WIDTH     = 512;
    localparam int LP_LANE_WIDTH     = 32;
    localparam int LP_MAX_K          = 16;
    localparam int LP_COUNT_WIDTH    = 32;

    localparam int LP_BASES_PER_LANE = LP_LANE_WIDTH / 2;
    localparam int LP_LANES_PER_BEAT = LP_DATA_WIDTH / LP_LANE_WIDTH;
    localparam int LP_HIST_BASES     = LP_BASES_PER_LANE - 1;
    localparam int LP_WIN_BASES      = LP_HIST_BASES + LP_BASES_PER_LANE;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'd0;
    localparam base_t BASE_C = 2'd1;
    localparam base_t BASE_G = 2'd2;
    localparam base_t BASE_T = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNPACK = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Patterns longer than one lane cannot be matched; clamp to the lane size.
    function automatic logic [4:0] clamp_k(input logic [4:0] k);
        return (k > 5'(LP_MAX_K)) ? 5'(LP_MAX_K) : k;
    endfunction

endpackage

// File: rtl/genome_lane_matcher.sv
// Combinational matcher: counts pattern hits ending at each of the 16 new
// bases of a 31-base window (15 history bases followed by the new lane).
module genome_lane_matcher
    import genome_pkg::*;
#(
    parameter int C_COUNT_WIDTH = LP_COUNT_WIDTH
) (
    input  logic [2*LP_WIN_BASES-1:0] window,
    input  logic [2*LP_MAX_K-1:0]     pattern,
    input  logic [4:0]                k_eff,
    input  logic [C_COUNT_WIDTH-1:0]  base_cnt,
    output logic [4:0]                match_cnt
);

    logic [LP_BASES_PER_LANE-1:0] hit;
    logic                         all_eq;
    int                           idx;
    logic [C_COUNT_WIDTH:0]       seen;

    // Per end position j: compare the k_eff bases ending at window[15+j]
    // and reject windows reaching back before the first base of the job.
    always_comb begin
        hit    = '0;
        all_eq = 1'b0;
        idx    = 0;
        seen   = '0;
        for (int j = 0; j < LP_BASES_PER_LANE; j++) begin
            all_eq = (k_eff != 5'd0);
            for (int m = 0; m < LP_MAX_K; m++) begin
                if (m < int'(k_eff)) begin
                    idx = LP_BASES_PER_LANE + j - int'(k_eff) + m;
                    if (window[2*idx +: 2] != pattern[2*m +: 2]) begin
                        all_eq = 1'b0;
                    end
                end
            end
            // base_cnt + j >= k_eff - 1, written without the k_eff=0 underflow
            seen = {1'b0, base_cnt} + (C_COUNT_WIDTH+1)'(j + 1);
            if (seen < (C_COUNT_WIDTH+1)'(k_eff)) begin
                all_eq = 1'b0;
            end
            hit[j] = all_eq;
        end
    end

    // Population count of the valid hits (0..16).
    always_comb begin
        match_cnt = '0;
        for (int j = 0; j < LP_BASES_PER_LANE; j++) begin
            match_cnt = match_cnt + 5'(hit[j]);
        end
    end

endmodule

// File: rtl/genome_kmer_counter.sv
// Streams 512-bit beats of packed bases, unpacks one 16-base lane per cycle
// and counts overlapping occurrences of a 1..16 base pattern over a job.
//
// Stream handshake: a beat transfers on a rising aclk edge where both
// s_axis_tvalid and s_axis_tready are high. tready is high in LOAD, and in
// UNPACK only on the last lane of a non-final beat so the next beat lands
// exactly as the current one is exhausted. tvalid may drop at any time.
module genome_kmer_counter
    import genome_pkg::*;
#(
    parameter int C_DATA_WIDTH  = LP_DATA_WIDTH,
    parameter int C_LANE_WIDTH  = LP_LANE_WIDTH,
    parameter int C_MAX_K       = LP_MAX_K,
    parameter int C_COUNT_WIDTH = LP_COUNT_WIDTH
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     ap_start,
    output logic                     ap_done,
    input  logic [2*C_MAX_K-1:0]     ctrl_pattern,
    input  logic [4:0]               ctrl_k,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [C_DATA_WIDTH-1:0]  s_axis_tdata,
    output logic [C_COUNT_WIDTH-1:0] match_count
);

    localparam int LANES  = C_DATA_WIDTH / C_LANE_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t                     state_q, state_d;
    logic [2*C_MAX_K-1:0]       pattern_q, pattern_d;
    logic [4:0]                 k_eff_q, k_eff_d;
    logic [C_DATA_WIDTH-1:0]    beat_q, beat_d;
    logic                       last_q, last_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [2*LP_HIST_BASES-1:0] hist_q, hist_d;
    logic [C_COUNT_WIDTH-1:0]   base_cnt_q, base_cnt_d;
    logic [C_COUNT_WIDTH-1:0]   match_count_q, match_count_d;

    logic                       handshake;
    logic                       at_last_lane;
    logic [C_LANE_WIDTH-1:0]    lane_bases;
    logic [2*LP_WIN_BASES-1:0]  window;
    logic [4:0]                 lane_matches;
    logic [C_COUNT_WIDTH:0]     mc_sum;
    logic [C_COUNT_WIDTH:0]     bc_sum;

    assign handshake    = s_axis_tvalid && s_axis_tready;
    assign at_last_lane = (lane_q == LAST_LANE);
    assign lane_bases   = beat_q[int'(lane_q)*C_LANE_WIDTH +: C_LANE_WIDTH];
    // Oldest history base sits at the bottom, new lane bases above it.
    assign window       = {lane_bases, hist_q};
    assign match_count  = match_count_q;

    genome_lane_matcher #(
        .C_COUNT_WIDTH (C_COUNT_WIDTH)
    ) u_lane_matcher (
        .window    (window),
        .pattern   (pattern_q),
        .k_eff     (k_eff_q),
        .base_cnt  (base_cnt_q),
        .match_cnt (lane_matches)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            pattern_q     <= '0;
            k_eff_q       <= '0;
            beat_q        <= '0;
            last_q        <= 1'b0;
            lane_q        <= '0;
            hist_q        <= '0;
            base_cnt_q    <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            k_eff_q       <= k_eff_d;
            beat_q        <= beat_d;
            last_q        <= last_d;
            lane_q        <= lane_d;
            hist_q        <= hist_d;
            base_cnt_q    <= base_cnt_d;
            match_count_q <= match_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (ap_start) state_d = LOAD;
            LOAD:   if (handshake) state_d = UNPACK;
            UNPACK: begin
                if (at_last_lane) begin
                    if (last_q)         state_d = DONE;
                    else if (handshake) state_d = UNPACK;
                    else                state_d = LOAD;
                end
            end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: stream ready and the done pulse.
    always_comb begin
        s_axis_tready = 1'b0;
        ap_done       = 1'b0;
        case (state_q)
            LOAD:    s_axis_tready = 1'b1;
            UNPACK:  s_axis_tready = at_last_lane && !last_q;
            DONE:    ap_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: job setup, beat capture, lane consumption and saturating counts.
    always_comb begin
        pattern_d     = pattern_q;
        k_eff_d       = k_eff_q;
        beat_d        = beat_q;
        last_d        = last_q;
        lane_d        = lane_q;
        hist_d        = hist_q;
        base_cnt_d    = base_cnt_q;
        match_count_d = match_count_q;
        mc_sum        = {1'b0, match_count_q} + (C_COUNT_WIDTH+1)'(lane_matches);
        bc_sum        = {1'b0, base_cnt_q} + (C_COUNT_WIDTH+1)'(LP_BASES_PER_LANE);
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    pattern_d     = ctrl_pattern;
                    k_eff_d       = clamp_k(ctrl_k);
                    match_count_d = '0;
                    hist_d        = '0;
                    base_cnt_d    = '0;
                    lane_d        = '0;
                    last_d        = 1'b0;
                end
            end
            LOAD: begin
                if (handshake) begin
                    beat_d = s_axis_tdata;
                    last_d = s_axis_tlast;
                    lane_d = '0;
                end
            end
            UNPACK: begin
                match_count_d = mc_sum[C_COUNT_WIDTH] ? '1 : mc_sum[C_COUNT_WIDTH-1:0];
                base_cnt_d    = bc_sum[C_COUNT_WIDTH] ? '1 : bc_sum[C_COUNT_WIDTH-1:0];
                hist_d        = window[2*LP_WIN_BASES-1 : 2*LP_BASES_PER_LANE];
                lane_d        = at_last_lane ? '0 : lane_q + 1'b1;
                if (at_last_lane && handshake) begin
                    beat_d = s_axis_tdata;
                    last_d = s_axis_tlast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_genome_kmer_counter.sv
// Directed bench for genome_kmer_counter: stimulus pushes expected counts and
// done cycles into queues; an independent monitor pops them on ap_done.
module tb_genome_kmer_counter;

    logic         aclk = 1'b0;
    logic         areset;
    logic         ap_start;
    logic         ap_done;
    logic [31:0]  ctrl_pattern;
    logic [4:0]   ctrl_k;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [511:0] s_axis_tdata;
    logic [31:0]  match_count;

    genome_kmer_counter dut (
        .aclk          (aclk),
        .areset        (areset),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ctrl_pattern  (ctrl_pattern),
        .ctrl_k        (ctrl_k),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .match_count   (match_count)
    );

    // Clock and cycle counter
    always #5 aclk = ~aclk;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Scoreboard state
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_done = 1'b0;

    // Vectors
    logic [511:0] acgt_beat;
    logic [511:0] all_a_beat;
    logic [511:0] gatt_beat1;
    logic [511:0] gatt_beat2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare count and completion cycle on every ap_done
    always @(negedge aclk) begin
        if (areset) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_pulse_width", {31'd0, ap_done}, 32'd0);
            if (ap_done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: ap_done with count %0d, none expected", match_count);
                end else begin
                    logic [31:0] e_cnt;
                    int          e_cyc;
                    e_cnt = exp_q.pop_front();
                    e_cyc = exp_cyc_q.pop_front();
                    check("match_count", match_count, e_cnt);
                    check("done_cycle", cyc, e_cyc);
                end
            end
            prev_done = ap_done;
        end
    end

    // Driver tasks (all entered and left on a falling edge)
    task automatic start_job(input logic [31:0] pat, input logic [4:0] k);
        @(negedge aclk);
        ctrl_pattern = pat;
        ctrl_k       = k;
        ap_start     = 1'b1;
        @(negedge aclk);
        ap_start     = 1'b0;
    endtask

    task automatic send_beat(input logic [511:0] d, input logic last, input int gap,
                             input logic [31:0] exp_cnt, output int hs_cyc);
        int budget;
        s_axis_tvalid = 1'b0;
        repeat (gap) @(negedge aclk);
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        budget = 0;
        while (!s_axis_tready && budget < 200) begin
            @(negedge aclk);
            budget++;
        end
        hs_cyc = cyc;
        if (!s_axis_tready) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: tready low for %0d cycles, required high", budget);
        end else if (last) begin
            exp_q.push_back(exp_cnt);
            exp_cyc_q.push_back(cyc + 17);
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(negedge aclk);
            b++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: %0d jobs outstanding, required 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int h0, h1, h2, h3;
        acgt_beat  = {64{8'hE4}};
        all_a_beat = '0;
        gatt_beat1 = '0;
        gatt_beat1[509:508] = 2'b10;   // base 254 = G, base 255 = A
        gatt_beat2 = '0;
        gatt_beat2[3:0] = 4'hF;        // bases 0,1 = T,T

        areset = 1'b1;
        ap_start = 1'b0;
        ctrl_pattern = '0;
        ctrl_k = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tdata = '0;
        repeat (3) @(negedge aclk);
        check("reset_tready", {31'd0, s_axis_tready}, 32'd0);
        check("reset_done", {31'd0, ap_done}, 32'd0);
        check("reset_count", match_count, 32'd0);
        areset = 1'b0;

        // ACGT x64, k=4
        start_job(32'h0000_00E4, 5'd4);
        send_beat(acgt_beat, 1'b1, 0, 32'd64, h0);
        wait_done();

        // k=16 all-A over two beats; ap_start during UNPACK must be ignored
        start_job(32'h0000_0000, 5'd16);
        send_beat(all_a_beat, 1'b0, 0, 32'd0, h0);
        start_job(32'hFFFF_FFFF, 5'd0);
        send_beat(all_a_beat, 1'b1, 0, 32'd497, h1);
        wait_done();

        // GATT straddling the beat boundary
        start_job(32'h0000_00F2, 5'd4);
        send_beat(gatt_beat1, 1'b0, 0, 32'd0, h0);
        send_beat(gatt_beat2, 1'b1, 0, 32'd1, h1);
        wait_done();

        // Four back-to-back beats
        start_job(32'h0000_00E4, 5'd4);
        send_beat(acgt_beat, 1'b0, 0, 32'd0, h0);
        send_beat(acgt_beat, 1'b0, 0, 32'd0, h1);
        send_beat(acgt_beat, 1'b0, 0, 32'd0, h2);
        send_beat(acgt_beat, 1'b1, 0, 32'd256, h3);
        check("b2b_first_spacing", h1 - h0, 32'd16);
        check("b2b_last_handshake", h3 - h0, 32'd48);
        wait_done();

        // Same job with random tvalid gaps
        start_job(32'h0000_00E4, 5'd4);
        send_beat(acgt_beat, 1'b0, $urandom_range(0, 4), 32'd0, h0);
        send_beat(acgt_beat, 1'b0, $urandom_range(0, 4), 32'd0, h1);
        send_beat(acgt_beat, 1'b0, $urandom_range(0, 4), 32'd0, h2);
        send_beat(acgt_beat, 1'b1, $urandom_range(0, 4), 32'd256, h3);
        wait_done();

        // ctrl_k = 0: stream consumed, nothing counted
        start_job(32'h0000_0000, 5'd0);
        send_beat(all_a_beat, 1'b0, 1, 32'd0, h0);
        send_beat(all_a_beat, 1'b1, 0, 32'd0, h1);
        wait_done();

        // ctrl_k = 20 clamps to 16
        start_job(32'h0000_0000, 5'd20);
        send_beat(all_a_beat, 1'b0, 0, 32'd0, h0);
        send_beat(all_a_beat, 1'b1, 2, 32'd497, h1);
        wait_done();

        // Reset in the middle of UNPACK of a 3-beat job, then a fresh job
        start_job(32'h0000_0000, 5'd16);
        send_beat(all_a_beat, 1'b0, 0, 32'd0, h0);
        repeat (5) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check("midjob_reset_tready", {31'd0, s_axis_tready}, 32'd0);
        check("midjob_reset_done", {31'd0, ap_done}, 32'd0);
        check("midjob_reset_count", match_count, 32'd0);
        start_job(32'h0000_00E4, 5'd4);
        send_beat(acgt_beat, 1'b1, 0, 32'd64, h0);
        wait_done();

        repeat (3) @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/genome_kmer_counter.md
Name: genome_kmer_counter

Overview:
- Downstream consumer of the genome read stage's 512-bit AXI4-Stream of packed 2-bit bases.
- Counts every occurrence, including overlapping ones, of a programmable pattern of 1..16 bases across the whole transfer.
- Matches that straddle lane and beat boundaries are counted.
- Reports the final count with a one-cycle ap_done pulse for the host control path.

Parameters:
C_DATA_WIDTH, 512, stream beat width; must be a multiple of C_LANE_WIDTH
C_LANE_WIDTH, 32, bits processed per cycle (16 bases)
C_MAX_K, 16, maximum pattern length in bases; equals bases per lane
C_COUNT_WIDTH, 32, match counter width

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
ap_start  in  1  start pulse; sampled only in IDLE
ap_done  out  1  one-cycle pulse when match_count is final
ctrl_pattern  in  2*C_MAX_K  pattern; base m at bits [2m+1:2m], base 0 oldest
ctrl_k  in  5  pattern length in bases
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  final beat of job
s_axis_tdata  in  C_DATA_WIDTH  packed bases; base i at bits [2i+1:2i], base 0 first in stream order
match_count  out  C_COUNT_WIDTH  matches in last job; held until next ap_start

Behaviour:
- Reset state: state=IDLE; s_axis_tready=0, ap_done=0, match_count=0; history, base counter and lane index cleared.
- Reset mid-job aborts the job and drops any captured beat. No residual history is carried into the next job.
- Base encoding: A=0, C=1, G=2, T=3.
- IDLE, on ap_start: latch ctrl_pattern and k_eff; clear match_count, the 15-base history and base_cnt; go to LOAD.
- k_eff = min(ctrl_k, 16). If ctrl_k=0, no match is ever counted but the stream is still consumed.
- LOAD: tready=1. On handshake, capture tdata into beat_q and tlast into last_q; set lane=0; go to UNPACK.
- UNPACK: processes lane `lane` (bases 16*lane..16*lane+15 of beat_q) each cycle, then increments lane.
  - tready=1 only when lane=15 and last_q=0, allowing back-to-back beats at 16 cycles per beat.
  - lane=15 with handshake: recapture the beat, lane=0, stay in UNPACK.
  - lane=15, last_q=0, no handshake: go to LOAD.
  - lane=15, last_q=1: go to DONE.
- DONE: ap_done=1 for exactly one cycle; go to IDLE.
- Lane match, per UNPACK cycle:
  - Build window arr[0..30] = history (15 bases, oldest first) followed by the 16 new lane bases.
  - Position j (0..15) matches if arr[16+j-k_eff+m] == pattern[m] for all m < k_eff, and base_cnt+j >= k_eff-1.
  - match_count += popcount of the matching positions (0..16).
  - history <= arr[16..30]; base_cnt += 16.
- Arithmetic: match_count and base_cnt both saturate at all-ones and never wrap.
- Latency: tlast beat accepted at cycle T → lanes processed T+1..T+16 → ap_done=1 and match_count final at T+17.
- ap_start outside IDLE is ignored.
- tvalid may drop at any time; state holds in LOAD with no counting.
- The tlast beat is always fully processed (all 16 lanes).

Decomposition:
- Package genome_pkg:
  - base_t (2-bit) and base encoding constants
  - LP_BASES_PER_LANE=16, LP_LANES_PER_BEAT = C_DATA_WIDTH/C_LANE_WIDTH
  - state enum {IDLE, LOAD, UNPACK, DONE}
- Sub-module genome_lane_matcher: purely combinational.
  - Inputs: 31-base window, pattern, k_eff, base_cnt.
  - Output: 5-bit popcount of valid matching positions.
- The top level holds the FSM, beat register, history, counters and handshake.

Test Plan:
- ACGT, k=4; one beat of ACGT×64 with tlast, handshake at T → ap_done at T+17, match_count=64.
- Straddling boundaries, k=16 all-A:
  - Two beats all A, second with tlast → match_count=497 (512-15), exercising cross-lane and cross-beat history.
  - Job 2: pattern GATT, k=4, base A background; GATT at bases 254..257 across beats 1/2 → match_count=1.
- Throughput and stalls:
  - 4 beats presented back-to-back → tready high one cycle per 16, last handshake at cycle 48 after the first, ap_done 17 cycles later.
  - Random tvalid gaps → same count as the gap-free run.
- Length edge cases on a 2-beat job:
  - ctrl_k=0 → match_count=0, ap_done still pulses.
  - ctrl_k=20 with all-A 16-base pattern on all-A data → 497.
- areset asserted mid-UNPACK of a 3-beat job, then a new job (ACGT×64 beat, k=4) → match_count=64, no leakage of old history; ap_start pulsed while in UNPACK → ignored.
